// File: rtl/pw_weight_pingpong_sched.sv
// Pointwise weight tile ping-pong scheduler: streams each tile into the inactive
// bank, commits it once compute is free, and launches compute on the committed tile.
module pw_weight_pingpong_sched #(
    parameter int BEATS  = 64,
    parameter int TILE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    output logic              busy,
    output logic              done,
    input  logic              src_valid,
    input  logic [127:0]      src_data,
    output logic              src_ready,
    output logic              load_start,
    output logic              w_valid,
    output logic [127:0]      w_data,
    output logic              w_done,
    input  logic              load_done,
    output logic              bank_commit,
    output logic              tile_go,
    output logic [TILE_W-1:0] tile_idx,
    input  logic              compute_done
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        L_IDLE,
        L_START,
        L_STREAM,
        L_END,
        L_WAIT,
        L_FULL
    } loader_t;

    loader_t           r_lstate;
    logic [BW-1:0]     r_beat_cnt;
    logic [TILE_W-1:0] r_ntiles;
    logic [TILE_W-1:0] r_loaded;
    logic [TILE_W-1:0] r_issued;
    logic [TILE_W-1:0] r_tile_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_comp_busy;
    logic              r_tile_go;

    logic w_commit;
    logic w_accept;
    logic w_job_end;

    // Commit only from a parked loader and an idle engine, so the buffer never
    // sees load_start and bank_commit together.
    assign w_commit  = (r_lstate == L_FULL) && !r_comp_busy;
    assign w_accept  = (r_lstate == L_STREAM) && src_valid;
    // The last compute_done ends the job directly, so done lands the cycle after it.
    assign w_job_end = r_busy && (r_issued == r_ntiles) && (r_loaded == r_ntiles)
                       && (!r_comp_busy || compute_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lstate    <= L_IDLE;
            r_beat_cnt  <= '0;
            r_ntiles    <= '0;
            r_loaded    <= '0;
            r_issued    <= '0;
            r_tile_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_comp_busy <= 1'b0;
            r_tile_go   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_tile_go <= 1'b0;

            if (start && !r_busy) begin
                r_ntiles <= num_tiles;
                if (num_tiles == '0) r_done <= 1'b1;
                else                 r_busy <= 1'b1;
            end

            if (w_commit) begin
                r_comp_busy <= 1'b1;
                r_tile_go   <= 1'b1;
                r_tile_idx  <= r_issued;
                r_issued    <= r_issued + 1'b1;
            end else if (compute_done) begin
                r_comp_busy <= 1'b0;
            end

            case (r_lstate)
                L_IDLE:   if (r_busy && (r_loaded < r_ntiles)) r_lstate <= L_START;
                L_START:  r_lstate <= L_STREAM;
                L_STREAM: if (w_accept) begin
                    r_beat_cnt <= r_beat_cnt + BW'(1);
                    if (r_beat_cnt == BW'(BEATS - 1)) r_lstate <= L_END;
                end
                L_END: begin
                    r_beat_cnt <= '0;
                    r_lstate   <= L_WAIT;
                end
                L_WAIT:   if (load_done) begin
                    r_loaded <= r_loaded + 1'b1;
                    r_lstate <= L_FULL;
                end
                L_FULL:   if (w_commit) r_lstate <= L_IDLE;
                default:  r_lstate <= L_IDLE;
            endcase

            if (w_job_end) begin
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_issued    <= '0;
                r_loaded    <= '0;
                r_comp_busy <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign src_ready   = (r_lstate == L_STREAM);
    assign load_start  = (r_lstate == L_START);
    assign w_valid     = w_accept;
    assign w_data      = src_data;
    assign w_done      = (r_lstate == L_END);
    assign bank_commit = w_commit;
    assign tile_go     = r_tile_go;
    assign tile_idx    = r_tile_idx;

endmodule

// File: tb/tb_pw_weight_pingpong_sched.sv
// Randomized bench for the PW weight ping-pong scheduler; expected event cycles come
// from the load/compute timing rules applied to the stimulus actually issued.
module tb_pw_weight_pingpong_sched;
    localparam int BEATS  = 64;
    localparam int TILE_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [TILE_W-1:0] num_tiles = '0;
    logic              src_valid = 1'b0;
    logic [127:0]      src_data = '0;
    logic              load_done = 1'b0;
    logic              compute_done = 1'b0;
    logic              busy, done, src_ready, load_start, w_valid, w_done;
    logic              bank_commit, tile_go;
    logic [127:0]      w_data;
    logic [TILE_W-1:0] tile_idx;

    pw_weight_pingpong_sched #(.BEATS(BEATS), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .load_start(load_start), .w_valid(w_valid),
        .w_data(w_data), .w_done(w_done), .load_done(load_done),
        .bank_commit(bank_commit), .tile_go(tile_go), .tile_idx(tile_idx),
        .compute_done(compute_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment knobs and responder state
    int src_mode = 0, ld_delay = 1, comp_lat = 10;
    bit comp_rand = 1'b0, inj_ld = 1'b0, inj_cd = 1'b0;
    int ld_cnt = 0, cd_cnt = 0;
    int ld_q[$], cd_q[$];

    // Observed events
    int ls_q[$], wv_q[$], wd_q[$], bc_q[$], tg_q[$], ti_q[$], dn_q[$], beats_q[$];
    int cur_beats = 0, wdata_err = 0, ovl_err = 0;

    // Model expectations
    int e_ls[$], e_bc[$], e_tg[$];
    int e_done;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic step_n(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Buffer and compute responders plus the beat source.
    initial begin
        forever begin
            step();
            case (src_mode)
                0:       src_valid = 1'b1;
                1:       src_valid = (cyc % 3 == 0);
                default: src_valid = 1'($urandom_range(0, 1));
            endcase
            src_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_done    = 1'b0;
            compute_done = 1'b0;
            if (!rst_n) begin
                ld_cnt = 0;
                cd_cnt = 0;
            end else begin
                if (ld_cnt > 0) begin
                    ld_cnt--;
                    if (ld_cnt == 0) begin load_done = 1'b1; ld_q.push_back(cyc); end
                end
                if (cd_cnt > 0) begin
                    cd_cnt--;
                    if (cd_cnt == 0) begin compute_done = 1'b1; cd_q.push_back(cyc); end
                end
                if (w_done)  ld_cnt = ld_delay;
                if (tile_go) cd_cnt = comp_rand ? int'($urandom_range(1, 150)) : comp_lat;
            end
            if (inj_ld) begin load_done = 1'b1; inj_ld = 1'b0; end
            if (inj_cd) begin compute_done = 1'b1; inj_cd = 1'b0; end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (load_start) begin ls_q.push_back(cyc); cur_beats = 0; end
                if (w_valid) begin
                    wv_q.push_back(cyc);
                    cur_beats++;
                    if (!src_valid || !src_ready || w_data !== src_data) wdata_err++;
                end
                if (w_done) begin wd_q.push_back(cyc); beats_q.push_back(cur_beats); end
                if (bank_commit) begin
                    bc_q.push_back(cyc);
                    if (load_start) ovl_err++;
                end
                if (tile_go) begin
                    tg_q.push_back(cyc);
                    ti_q.push_back(int'(tile_idx));
                    $display("cyc %0d: tile_go tile_idx=%0d", cyc, tile_idx);
                end
                if (done) begin
                    dn_q.push_back(cyc);
                    $display("cyc %0d: job done", cyc);
                end
            end
        end
    end

    task automatic clear_mon();
        ld_q.delete(); cd_q.delete(); ls_q.delete(); wv_q.delete(); wd_q.delete();
        bc_q.delete(); tg_q.delete(); ti_q.delete(); dn_q.delete(); beats_q.delete();
        wdata_err = 0; ovl_err = 0; cur_beats = 0;
    endtask

    task automatic do_start(input int n, output int t0);
        step();
        start = 1'b1;
        num_tiles = TILE_W'(n);
        t0 = cyc;
        step();
        start = 1'b0;
        num_tiles = TILE_W'($urandom());
    endtask

    task automatic wait_done(input int budget, output bit ok);
        for (int i = 0; i < budget && dn_q.size() == 0; i++) step();
        ok = (dn_q.size() != 0);
    endtask

    // Tile i commits once it is loaded and tile i-1 has finished computing;
    // the next load can only start two cycles after the previous commit.
    task automatic model_job(input int n, input int t0);
        int full, rdy;
        e_ls.delete(); e_bc.delete(); e_tg.delete();
        e_done = -1;
        for (int i = 0; i < n && i < ld_q.size(); i++) begin
            if (i > 0 && i - 1 >= cd_q.size()) break;
            full = ld_q[i] + 1;
            rdy  = (i == 0) ? 0 : cd_q[i-1] + 1;
            e_ls.push_back((i == 0) ? t0 + 2 : e_bc[i-1] + 2);
            e_bc.push_back((full > rdy) ? full : rdy);
            e_tg.push_back(e_bc[i] + 1);
        end
        if (n > 0 && cd_q.size() >= n) e_done = cd_q[n-1] + 1;
    endtask

    task automatic test_reset();
        step_n(3);
        if ({busy, done, src_ready, w_valid, load_start, w_done, bank_commit, tile_go} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b required 00000000",
                     {busy, done, src_ready, w_valid, load_start, w_done, bank_commit, tile_go});
            n_fail++;
        end
        n_checks++;
        if (tile_idx !== '0) begin $display("FAIL reset_idx: got %0d required 0", tile_idx); n_fail++; end
        n_checks++;
        rst_n = 1'b1;
        step_n(2);
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b required 0", busy); n_fail++; end
        n_checks++;
    endtask

    task automatic test_single();
        int t0; bit ok;
        src_mode = 0; comp_lat = 10; comp_rand = 1'b0; ld_delay = 1;
        clear_mon();
        do_start(1, t0);
        if (busy !== 1'b1) begin $display("FAIL single_busy: got %b required 1", busy); n_fail++; end
        n_checks++;
        wait_done(500, ok);
        step();
        if (ok !== 1'b1) begin $display("FAIL single_timeout: got %b required 1", ok); n_fail++; end
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL single_busy_end: got %b required 0", busy); n_fail++; end
        n_checks++;
        step_n(5);
        if (ls_q.size() != 1 || ls_q[0] != t0 + 2) begin
            $display("FAIL single_load_start: got n=%0d c=%0d required c=%0d", ls_q.size(),
                     ls_q.size() ? ls_q[0] - t0 : -1, 2); n_fail++; end
        n_checks++;
        if (wv_q.size() != BEATS || wv_q[0] != t0 + 3 || wv_q[wv_q.size()-1] != t0 + 2 + BEATS) begin
            $display("FAIL single_beats: got n=%0d required %0d from T+3", wv_q.size(), BEATS); n_fail++; end
        n_checks++;
        if (wd_q.size() != 1 || wd_q[0] != t0 + 3 + BEATS) begin
            $display("FAIL single_w_done: got %0d required %0d", wd_q.size() ? wd_q[0] - t0 : -1, 3 + BEATS); n_fail++; end
        n_checks++;
        if (bc_q.size() != 1 || bc_q[0] != t0 + 5 + BEATS) begin
            $display("FAIL single_commit: got %0d required %0d", bc_q.size() ? bc_q[0] - t0 : -1, 5 + BEATS); n_fail++; end
        n_checks++;
        if (tg_q.size() != 1 || tg_q[0] != t0 + 6 + BEATS || ti_q[0] != 0) begin
            $display("FAIL single_tile_go: got %0d required %0d idx 0", tg_q.size() ? tg_q[0] - t0 : -1, 6 + BEATS); n_fail++; end
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0] != t0 + 6 + BEATS + 10 + 1) begin
            $display("FAIL single_done: got %0d required %0d", dn_q.size() ? dn_q[0] - t0 : -1, 17 + BEATS); n_fail++; end
        n_checks++;
    endtask

    task automatic test_zero();
        int t0;
        clear_mon();
        do_start(0, t0);
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL zero_done: got done=%b busy=%b required done=1 busy=0", done, busy); n_fail++; end
        n_checks++;
        step_n(10);
        if (ls_q.size() + bc_q.size() + tg_q.size() != 0 || dn_q.size() != 1) begin
            $display("FAIL zero_quiet: got ls=%0d bc=%0d tg=%0d done=%0d required 0 0 0 1",
                     ls_q.size(), bc_q.size(), tg_q.size(), dn_q.size()); n_fail++; end
        n_checks++;
    endtask

    task automatic test_scenario(input string nm, input int n, input int mode, input int lat,
                                 input bit crand, input int ldd);
        int t0; bit ok;
        src_mode = mode; comp_lat = lat; comp_rand = crand; ld_delay = ldd;
        clear_mon();
        do_start(n, t0);
        wait_done(30000, ok);
        step_n(5);
        if (ok !== 1'b1) begin $display("FAIL %s_timeout: got %b required 1", nm, ok); n_fail++; end
        n_checks++;
        model_job(n, t0);
        if (bc_q.size() != n || tg_q.size() != n || ls_q.size() != n || e_bc.size() != n) begin
            $display("FAIL %s_counts: got bc=%0d tg=%0d ls=%0d model=%0d required %0d",
                     nm, bc_q.size(), tg_q.size(), ls_q.size(), e_bc.size(), n); n_fail++; end
        n_checks++;
        for (int i = 0; i < n && i < bc_q.size() && i < tg_q.size() && i < ls_q.size() && i < e_bc.size(); i++) begin
            if (ls_q[i] != e_ls[i] || bc_q[i] != e_bc[i] || tg_q[i] != e_tg[i] || ti_q[i] != i) begin
                $display("FAIL %s_tile%0d: got ls=%0d bc=%0d tg=%0d idx=%0d required %0d %0d %0d %0d",
                         nm, i, ls_q[i], bc_q[i], tg_q[i], ti_q[i], e_ls[i], e_bc[i], e_tg[i], i); n_fail++; end
            n_checks++;
        end
        for (int i = 0; i < beats_q.size(); i++) begin
            if (beats_q[i] != BEATS) begin
                $display("FAIL %s_beats%0d: got %0d required %0d", nm, i, beats_q[i], BEATS); n_fail++; end
            n_checks++;
        end
        if (wdata_err != 0 || ovl_err != 0) begin
            $display("FAIL %s_stream: got wdata_err=%0d overlap=%0d required 0 0", nm, wdata_err, ovl_err); n_fail++; end
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0] != e_done) begin
            $display("FAIL %s_done: got %0d required %0d", nm, dn_q.size() ? dn_q[0] : -1, e_done); n_fail++; end
        n_checks++;
    endtask

    task automatic test_overlap_park();
        // Long compute: the next tile finishes loading well before compute_done.
        test_scenario("multi", 3, 0, 200, 1'b0, 1);
        if (ld_q.size() < 2 || cd_q.size() < 1 || ld_q[1] >= cd_q[0]) begin
            $display("FAIL multi_overlap: got ld1=%0d cd0=%0d required ld1<cd0",
                     ld_q.size() > 1 ? ld_q[1] : -1, cd_q.size() ? cd_q[0] : -1); n_fail++; end
        n_checks++;
    endtask

    task automatic test_illegal();
        int t0; bit ok;
        src_mode = 0; comp_lat = 50; comp_rand = 1'b0; ld_delay = 1;
        clear_mon();
        do_start(2, t0);
        step_n(4);
        inj_ld = 1'b1;
        inj_cd = 1'b1;
        step_n(2);
        start = 1'b1;
        num_tiles = TILE_W'(9);
        step();
        start = 1'b0;
        wait_done(5000, ok);
        step_n(10);
        if (ok !== 1'b1) begin $display("FAIL illegal_timeout: got %b required 1", ok); n_fail++; end
        n_checks++;
        if (bc_q.size() != 2 || ti_q.size() != 2 || ls_q.size() != 2) begin
            $display("FAIL illegal_counts: got bc=%0d tg=%0d ls=%0d required 2", bc_q.size(), ti_q.size(), ls_q.size()); n_fail++; end
        n_checks++;
        if (bc_q.size() > 0 && ld_q.size() > 0 && bc_q[0] != ld_q[0] + 1) begin
            $display("FAIL illegal_commit0: got %0d required %0d", bc_q[0], ld_q[0] + 1); n_fail++; end
        n_checks++;
        if (dn_q.size() != 1 || cd_q.size() != 2 || dn_q[0] != cd_q[1] + 1) begin
            $display("FAIL illegal_done: got n=%0d c=%0d required 1 pulse after 2nd compute_done",
                     dn_q.size(), dn_q.size() ? dn_q[0] : -1); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_midstream();
        int t0; bit ok;
        src_mode = 0; comp_lat = 30; comp_rand = 1'b0; ld_delay = 2;
        clear_mon();
        do_start(2, t0);
        for (int i = 0; i < 200 && cur_beats < 30; i++) step();
        rst_n = 1'b0;
        #1;
        if ({busy, done, src_ready, w_valid, load_start, w_done, bank_commit, tile_go} !== 8'h00 || tile_idx !== '0) begin
            $display("FAIL midreset_outputs: got %b idx=%0d required 0",
                     {busy, done, src_ready, w_valid, load_start, w_done, bank_commit, tile_go}, tile_idx); n_fail++; end
        n_checks++;
        step_n(3);
        rst_n = 1'b1;
        step_n(2);
        test_scenario("after_reset", 2, 2, 40, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_overlap_park();
        test_scenario("stall", 2, 1, 20, 1'b0, 1);
        test_scenario("random", int'($urandom_range(2, 5)), 2, 0, 1'b1, int'($urandom_range(1, 4)));
        test_illegal();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
